// File: rtl/eip_sequencer.sv
// Instruction-pointer sequencer: advance, jumps, and call/return through a circular RAS.
// Optional EIP_PREV_EN macro adds the eip_prev trace output.
module eip_sequencer #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       RAS_DEPTH    = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                         clock_8,
    input  logic                         reset,
    input  logic                         step,
    input  logic [3:0]                   insn_len,
    input  logic [2:0]                   op,
    input  logic [ADDR_W-1:0]            target,
    output logic [ADDR_W-1:0]            eip,
`ifdef EIP_PREV_EN
    output logic [ADDR_W-1:0]            eip_prev,
`endif
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_full,
    output logic                         ras_empty,
    output logic                         ras_ovf,
    output logic                         ras_unf
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        OP_ADV     = 3'd0,
        OP_JMP_ABS = 3'd1,
        OP_JMP_REL = 3'd2,
        OP_CALL    = 3'd3,
        OP_RET     = 3'd4
    } op_t;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    logic [ADDR_W-1:0] eip_q, eip_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push;
    logic [ADDR_W-1:0] nxt;
    logic [PTR_W-1:0]  top_idx;
    op_t               op_e;

    // ptr_q is the next write slot; when full it also addresses the oldest entry,
    // so a push while full overwrites the oldest without extra bookkeeping.
    assign nxt     = eip_q + ADDR_W'(insn_len);
    assign top_idx = ptr_q - PTR_W'(1);
    assign op_e    = op_t'(op);

    always_comb begin
        eip_d = eip_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        push  = 1'b0;
        if (step) begin
            case (op_e)
                OP_JMP_ABS: eip_d = target;
                OP_JMP_REL: eip_d = nxt + target;
                OP_CALL: begin
                    push  = 1'b1;
                    eip_d = target;
                    ptr_d = ptr_q + PTR_W'(1);
                    if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (cnt_q != '0) begin
                        eip_d = ras_mem[top_idx];
                        ptr_d = top_idx;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        eip_d = nxt;
                        unf_d = 1'b1;
                    end
                end
                default: eip_d = nxt;
            endcase
        end
    end

    always_ff @(posedge clock_8) begin
        if (reset) begin
            eip_q <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            eip_q <= eip_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clock_8) begin
        if (push && !reset) begin
            ras_mem[ptr_q] <= nxt;
        end
    end

`ifdef EIP_PREV_EN
    logic [ADDR_W-1:0] eip_prev_q;

    always_ff @(posedge clock_8) begin
        if (reset) begin
            eip_prev_q <= RESET_VECTOR;
        end else if (step) begin
            eip_prev_q <= eip_q;
        end
    end

    assign eip_prev = eip_prev_q;
`endif

    assign eip       = eip_q;
    assign ras_count = cnt_q;
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_empty = (cnt_q == '0);
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_eip_sequencer.sv
// Scoreboard bench for eip_sequencer: driver queues hand-computed expectations,
// monitor checks each registered update shortly after the clock edge.
module tb_eip_sequencer;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned RAS_DEPTH = 8;

    localparam logic [2:0] ADV = 3'd0, JABS = 3'd1, JREL = 3'd2, CALL = 3'd3, RET = 3'd4;

    logic              clock_8 = 1'b0;
    logic              reset   = 1'b1;
    logic              step    = 1'b0;
    logic [3:0]        insn_len = '0;
    logic [2:0]        op      = '0;
    logic [31:0]       target  = '0;
    logic [31:0]       eip;
    logic [31:0]       eip_prev;
    logic [3:0]        ras_count;
    logic              ras_full, ras_empty, ras_ovf, ras_unf;

    eip_sequencer #(
        .ADDR_W      (ADDR_W),
        .RAS_DEPTH   (RAS_DEPTH),
        .RESET_VECTOR(32'h0)
    ) dut (
        .clock_8  (clock_8),
        .reset    (reset),
        .step     (step),
        .insn_len (insn_len),
        .op       (op),
        .target   (target),
        .eip      (eip),
`ifdef EIP_PREV_EN
        .eip_prev (eip_prev),
`endif
        .ras_count(ras_count),
        .ras_full (ras_full),
        .ras_empty(ras_empty),
        .ras_ovf  (ras_ovf),
        .ras_unf  (ras_unf)
    );

`ifndef EIP_PREV_EN
    assign eip_prev = '0;
`endif

    always #5 clock_8 = ~clock_8;

    typedef struct {
        int          id;
        logic [31:0] eip;
        int          cnt;
        logic        ovf;
        logic        unf;
        logic [31:0] prev;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          vec   = 0;
    logic [31:0] model_eip  = '0;
    logic [31:0] model_prev = '0;

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s vec%0d actual=%h required=%h", nm, id, act, req);
        end
    endtask

    // Inputs change on the falling edge; the expectation describes the state after the next rising edge.
    task automatic apply(input logic rst, input logic st, input logic [3:0] len, input logic [2:0] o,
                         input logic [31:0] tgt, input logic [31:0] e_eip, input int e_cnt,
                         input logic e_ovf, input logic e_unf);
        exp_t e;
        @(negedge clock_8);
        reset = rst; step = st; insn_len = len; op = o; target = tgt;
        if (rst) model_prev = 32'h0;
        else if (st) model_prev = model_eip;
        model_eip = e_eip;
        e.id = vec; e.eip = e_eip; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf; e.prev = model_prev;
        sb.push_back(e);
        vec++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock_8);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.id, "eip", eip, e.eip);
                chk(e.id, "ras_count", {28'b0, ras_count}, e.cnt);
                chk(e.id, "ras_full", {31'b0, ras_full}, {31'b0, e.cnt == RAS_DEPTH});
                chk(e.id, "ras_empty", {31'b0, ras_empty}, {31'b0, e.cnt == 0});
                chk(e.id, "ras_ovf", {31'b0, ras_ovf}, {31'b0, e.ovf});
                chk(e.id, "ras_unf", {31'b0, ras_unf}, {31'b0, e.unf});
`ifdef EIP_PREV_EN
                chk(e.id, "eip_prev", eip_prev, e.prev);
`endif
            end
        end
    end

    initial begin : driver
        // reset
        apply(1, 0, 0, ADV, 0, 32'h0, 0, 0, 0);
        apply(1, 1, 3, ADV, 0, 32'h0, 0, 0, 0);
        // sequential advance 1,2,4,5
        apply(0, 1, 1, ADV, 0, 32'd1, 0, 0, 0);
        apply(0, 1, 2, ADV, 0, 32'd3, 0, 0, 0);
        apply(0, 1, 4, ADV, 0, 32'd7, 0, 0, 0);
        apply(0, 1, 5, ADV, 0, 32'd12, 0, 0, 0);
        // wraparound of advance and relative jump
        apply(0, 1, 3, JABS, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 0, 0);
        apply(0, 1, 4, ADV, 0, 32'h0000_0002, 0, 0, 0);
        apply(0, 1, 2, JREL, 32'hFFFF_FFFC, 32'h0, 0, 0, 0);
        // unused opcodes behave as ADV; zero length holds
        apply(0, 1, 3, 3'd6, 32'h1234, 32'd3, 0, 0, 0);
        apply(0, 1, 0, 3'd7, 32'h1234, 32'd3, 0, 0, 0);
        apply(0, 1, 0, ADV, 0, 32'd3, 0, 0, 0);
        // single call/return
        apply(0, 1, 1, JABS, 32'h10, 32'h10, 0, 0, 0);
        apply(0, 1, 5, CALL, 32'h100, 32'h100, 1, 0, 0);
        apply(0, 1, 2, RET, 0, 32'h15, 0, 0, 0);
        // nine calls into an 8-deep RAS: return addresses 0x1,0x101..0x108, first one lost
        apply(0, 1, 1, JABS, 32'h0, 32'h0, 0, 0, 0);
        for (int k = 0; k < 9; k++)
            apply(0, 1, 1, CALL, 32'h100 + k, 32'h100 + k, (k < 8) ? k + 1 : 8, k == 8, 0);
        for (int j = 0; j < 8; j++)
            apply(0, 1, 1, RET, 0, 32'h108 - j, 7 - j, 0, 0);
        apply(0, 1, 1, RET, 0, 32'h102, 0, 0, 1);
        apply(0, 0, 1, RET, 0, 32'h102, 0, 0, 0);
        // idle with op=CALL must not push or move
        apply(0, 1, 1, CALL, 32'h200, 32'h200, 1, 0, 0);
        for (int i = 0; i < 10; i++)
            apply(0, 0, 4'd7, CALL, 32'h999, 32'h200, 1, 0, 0);
        apply(0, 1, 0, RET, 0, 32'h103, 0, 0, 0);
        // reset during a call chain discards the RAS
        apply(0, 1, 2, CALL, 32'h300, 32'h300, 1, 0, 0);
        apply(0, 1, 2, CALL, 32'h310, 32'h310, 2, 0, 0);
        apply(0, 1, 2, CALL, 32'h320, 32'h320, 3, 0, 0);
        apply(1, 1, 2, CALL, 32'h330, 32'h0, 0, 0, 0);
        apply(0, 1, 4, RET, 0, 32'h4, 0, 0, 1);
        apply(0, 1, 1, ADV, 0, 32'h5, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock_8);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
